expr_evaluator: RTL
===================

# expr_evaluator

Streaming arithmetic-expression checker and evaluator. Consumes one ASCII character per accepted cycle, verifies that the stream forms a legal expression of unsigned decimal numbers joined by binary operators and terminated by `=`, and produces the value with `*` binding tighter than `+`/`-`. It sits behind the character classifier stage of the expression datapath and generalises it to multi-digit numbers, parametrised result width, an optional subtraction mode and a registered result/done handshake.

## Interface
- `WIDTH`, 32, width of number, product, sum and result registers (>= 4).
- `ALLOW_SUB`, 0, when 1 `-` is a legal operator; when 0 `-` is an illegal character.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `in_char` is consumed on a rising edge where `in_valid`=1.
- `in_char`  input  8  ASCII character.
- `out_done`  output  1  one-cycle pulse: an expression just completed.
- `out_legal`  output  1  1 = last completed expression was legal; held until next `out_done`.
- `out_result`  output  WIDTH  value of last legal expression mod 2^WIDTH; 0 if illegal; held.
- `out_ovf`  output  1  sticky per expression; unsigned wrap occurred (ALLOW_SUB=0 only); held.

## Operation
- Character classes: digit `0`-`9`; operator `+`, `*`, and `-` if ALLOW_SUB=1; terminator `=`; everything else illegal.
- Registers: `num` (current number), `prod` (product of factors so far in the current term, signed via two's complement), `sum` (sum of completed terms), `ovf` (sticky).
- FSM states: S_START (expect first digit), S_NUM (inside a number), S_OP (operator seen, expect digit), S_ERR (illegal, absorbing).
- S_START/S_OP + digit -> S_NUM, `num` = digit.
- S_NUM + digit -> S_NUM, `num` = num*10 + digit. Leading zeros are legal.
- S_NUM + `*` -> S_OP, `prod` = prod*num, `num` = 0.
- S_NUM + `+` -> S_OP, `sum` = sum + prod*num, `prod` = 1, `num` = 0.
- S_NUM + `-` (ALLOW_SUB=1) -> S_OP, same as `+` but `prod` = all-ones (-1).
- S_NUM + `=` -> S_START, pulse `out_done`, `out_legal`=1, `out_result` = sum + prod*num, `out_ovf` = ovf (including the final accumulate).
- S_START/S_OP + operator or illegal char -> S_ERR. S_NUM + illegal char -> S_ERR.
- S_START/S_OP/S_ERR + `=` -> S_START, pulse `out_done`, `out_legal`=0, `out_result`=0, `out_ovf`=0. A lone `=` is illegal.
- S_ERR + any non-`=` -> S_ERR.
- Every return to S_START reloads `sum`=0, `prod`=1, `num`=0, `ovf`=0.
- Arithmetic: all operations truncated to WIDTH bits (mod 2^WIDTH). With ALLOW_SUB=0, `ovf` is set when any num*10+digit, prod*num or sum+prod*num true result exceeds 2^WIDTH-1. With ALLOW_SUB=1, `ovf` is held 0.
- `in_valid`=0: no state or register change; `out_done` is 0.

## Timing
- Reset values: state S_START, `num`=0, `prod`=1, `sum`=0, `ovf`=0, `out_done`=0, `out_legal`=0, `out_result`=0, `out_ovf`=0.
- Reset dominates `in_valid` on the same edge. A reset mid-expression discards all partial state and does not pulse `out_done`.
- Latency: `=` sampled at edge N drives `out_done`=1 and updates `out_legal`/`out_result`/`out_ovf` during cycle N..N+1. All outputs are registered.
- `out_done` lasts exactly one cycle unless another `=` is accepted on the next edge. Back-to-back `=` yields consecutive pulses, each for its own expression.
- No backpressure: one character is accepted every cycle with `in_valid`=1. A new expression may start on the cycle right after `=`.
- Idle cycles (`in_valid`=0) anywhere in a stream do not change the result.

## Test plan
- WIDTH=32: `12+3*4=` with one char per cycle -> single `out_done` pulse one cycle after `=`; `out_legal`=1, `out_result`=24, `out_ovf`=0.
- Illegal streams `2*+3=`, `=`, `+1=`, `1a=`, `3*=` -> each gives `out_done` with `out_legal`=0, `out_result`=0. A following `7=` -> `out_result`=7, `out_legal`=1.
- WIDTH=8: `255*2=` -> `out_result`=254, `out_ovf`=1. Then `007+1=` -> `out_result`=8, `out_ovf`=0.
- ALLOW_SUB=1, WIDTH=8: `5-2*3=` -> `out_result`=0xFF, `out_legal`=1. ALLOW_SUB=0: `5-2=` -> `out_legal`=0.
- `1+2*3=` with random `in_valid` gaps -> `out_result`=7. Back-to-back `4=9=` -> two consecutive `out_done` pulses with results 4 then 9.
- `12+` then `reset` for 1 cycle, then `7=` -> no `out_done` during reset, all outputs 0 after reset, then `out_result`=7.

Source files
------------

// File: rtl/expr_evaluator.sv
// Streaming evaluator for unsigned decimal expressions terminated by '='.
// '*' binds tighter than '+'/'-'; results are registered and held until the next '='.
module expr_evaluator #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          ALLOW_SUB = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             out_done,
  output logic             out_legal,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf
);

  localparam int unsigned NW = WIDTH + 4;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = WIDTH + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam bit TRACK_OVF = !ALLOW_SUB;

  typedef enum logic [1:0] {S_START, S_NUM, S_OP, S_ERR} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] num, num_d;
  logic [WIDTH-1:0] prod, prod_d;
  logic [WIDTH-1:0] sum, sum_d;
  logic             ovf, ovf_d;
  logic             done_d, legal_d, rovf_d;
  logic [WIDTH-1:0] result_d;

  // Character classification
  logic is_digit_c, is_plus_c, is_mul_c, is_minus_c, is_eq_c;
  logic [3:0] digit_c;

  assign is_digit_c = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_plus_c  = (in_char == 8'h2b);
  assign is_mul_c   = (in_char == 8'h2a);
  assign is_minus_c = ALLOW_SUB && (in_char == 8'h2d);
  assign is_eq_c    = (in_char == 8'h3d);
  assign digit_c    = in_char[3:0];

  // Wide intermediates: upper bits expose unsigned wrap of each step
  logic [NW-1:0] num_x10_c;
  logic [PW-1:0] prod_num_c;
  logic [AW-1:0] acc_c;
  logic          num_wrap_c, mul_wrap_c, add_wrap_c;

  assign num_x10_c  = NW'(num) * NW'(10) + NW'(digit_c);
  assign prod_num_c = PW'(prod) * PW'(num);
  assign acc_c      = AW'(sum) + AW'(prod_num_c[WIDTH-1:0]);
  assign num_wrap_c = |num_x10_c[NW-1:WIDTH];
  assign mul_wrap_c = |prod_num_c[PW-1:WIDTH];
  assign add_wrap_c = acc_c[WIDTH];

  // Next-state and next-register logic
  always_comb begin
    state_d  = state;
    num_d    = num;
    prod_d   = prod;
    sum_d    = sum;
    ovf_d    = ovf;
    done_d   = 1'b0;
    legal_d  = out_legal;
    result_d = out_result;
    rovf_d   = out_ovf;

    if (in_valid) begin
      if (is_eq_c) begin
        state_d = S_START;
        num_d   = '0;
        prod_d  = ONE;
        sum_d   = '0;
        ovf_d   = 1'b0;
        done_d  = 1'b1;
        if (state == S_NUM) begin
          legal_d  = 1'b1;
          result_d = acc_c[WIDTH-1:0];
          rovf_d   = TRACK_OVF && (ovf || mul_wrap_c || add_wrap_c);
        end else begin
          legal_d  = 1'b0;
          result_d = '0;
          rovf_d   = 1'b0;
        end
      end else begin
        case (state)
          S_START, S_OP: begin
            if (is_digit_c) begin
              state_d = S_NUM;
              num_d   = WIDTH'(digit_c);
            end else begin
              state_d = S_ERR;
            end
          end
          S_NUM: begin
            if (is_digit_c) begin
              num_d = num_x10_c[WIDTH-1:0];
              ovf_d = TRACK_OVF && (ovf || num_wrap_c);
            end else if (is_mul_c) begin
              state_d = S_OP;
              prod_d  = prod_num_c[WIDTH-1:0];
              num_d   = '0;
              ovf_d   = TRACK_OVF && (ovf || mul_wrap_c);
            end else if (is_plus_c || is_minus_c) begin
              // A '-' term is accumulated as (-1 * factors) in two's complement
              state_d = S_OP;
              sum_d   = acc_c[WIDTH-1:0];
              prod_d  = is_minus_c ? '1 : ONE;
              num_d   = '0;
              ovf_d   = TRACK_OVF && (ovf || mul_wrap_c || add_wrap_c);
            end else begin
              state_d = S_ERR;
            end
          end
          S_ERR:   state_d = S_ERR;
          default: state_d = S_ERR;
        endcase
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_START;
      num        <= '0;
      prod       <= ONE;
      sum        <= '0;
      ovf        <= 1'b0;
      out_done   <= 1'b0;
      out_legal  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else begin
      state      <= state_d;
      num        <= num_d;
      prod       <= prod_d;
      sum        <= sum_d;
      ovf        <= ovf_d;
      out_done   <= done_d;
      out_legal  <= legal_d;
      out_result <= result_d;
      out_ovf    <= rovf_d;
    end
  end

endmodule
